// File: rtl/vissue_ctrl.sv
// vissue_ctrl: single-entry vector issue controller.
// Holds one decoded micro-op, blocks it while any of its registers has a
// pending write, routes it to the execute or memory port, and turns vset
// micro-ops into a drain-then-pulse configuration sequence.
// Optional macro VISSUE_WB_BYPASS_EN: hazard and drain checks also see the
// writeback clears of the current cycle (saves one cycle per unblock).
module vissue_ctrl #(
  parameter int VECTOR_REGISTERS = 32,
  parameter int MICROOP_WIDTH    = 7,
  parameter int VL_WIDTH         = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [MICROOP_WIDTH-1:0] in_microop_i,
  input  logic [1:0]               in_fu_i,
  input  logic [4:0]               in_dst_i,
  input  logic [4:0]               in_src1_i,
  input  logic [4:0]               in_src2_i,
  input  logic                     in_writes_dst_i,
  input  logic                     in_reconfigure_i,
  input  logic [VL_WIDTH-1:0]      in_vl_i,
  output logic                     ex_valid_o,
  input  logic                     ex_ready_i,
  output logic                     mem_valid_o,
  input  logic                     mem_ready_i,
  output logic [MICROOP_WIDTH-1:0] iss_microop_o,
  output logic [4:0]               iss_dst_o,
  output logic [4:0]               iss_src1_o,
  output logic [4:0]               iss_src2_o,
  output logic [VL_WIDTH-1:0]      iss_vl_o,
  output logic                     cfg_valid_o,
  output logic [VL_WIDTH-1:0]      cfg_vl_o,
  input  logic                     wb_ex_valid_i,
  input  logic [4:0]               wb_ex_dst_i,
  input  logic                     wb_mem_valid_i,
  input  logic [4:0]               wb_mem_dst_i,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    CFG   = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [VECTOR_REGISTERS-1:0] pending;
  logic [VECTOR_REGISTERS-1:0] pending_nx;
  logic [VECTOR_REGISTERS-1:0] wb_clear;
  logic [VECTOR_REGISTERS-1:0] wb_set;
  logic [VECTOR_REGISTERS-1:0] pend_view;

  // held entry
  logic [MICROOP_WIDTH-1:0] e_microop;
  logic [1:0]               e_fu;
  logic [4:0]               e_dst;
  logic [4:0]               e_src1;
  logic [4:0]               e_src2;
  logic                     e_writes;
  logic [VL_WIDTH-1:0]      e_vl;

  logic hazard;
  logic fire;
  logic accept;

  // One-hot scoreboard mask for a register index, empty when not enabled.
  function automatic logic [VECTOR_REGISTERS-1:0] reg_bit(input logic en, input logic [4:0] idx);
    logic [VECTOR_REGISTERS-1:0] res;
    res = '0;
    if (en) begin
      res[idx] = 1'b1;
    end else begin
      res = '0;
    end
    return res;
  endfunction

  // Where a freshly accepted micro-op goes: vset drains, ex/mem ops are held,
  // anything else is dropped.
  function automatic state_t accept_target(input logic reconf, input logic [1:0] fu);
    state_t t;
    if (reconf) begin
      t = DRAIN;
    end else if ((fu == 2'b10) || (fu == 2'b00)) begin
      t = HOLD;
    end else begin
      t = EMPTY;
    end
    return t;
  endfunction

  assign wb_clear = reg_bit(wb_ex_valid_i, wb_ex_dst_i) | reg_bit(wb_mem_valid_i, wb_mem_dst_i);

`ifdef VISSUE_WB_BYPASS_EN
  assign pend_view = pending & ~wb_clear;
`else
  assign pend_view = pending;
`endif

  // Pending bits only fall while an entry is held, so once valid rises the
  // hazard cannot come back before the entry fires.
  assign hazard = pend_view[e_src1] | pend_view[e_src2] | (e_writes & pend_view[e_dst]);

  assign fire       = (ex_valid_o & ex_ready_i) | (mem_valid_o & mem_ready_i);
  assign in_ready_o = (state == EMPTY) | fire;
  assign accept     = in_valid_i & in_ready_o;

  // A set in the same cycle as a clear of the same register keeps the bit.
  assign wb_set     = reg_bit(fire & e_writes, e_dst);
  assign pending_nx = (pending & ~wb_clear) | wb_set;

  assign busy_o        = (state != EMPTY) | (|pending);
  assign iss_microop_o = e_microop;
  assign iss_dst_o     = e_dst;
  assign iss_src1_o    = e_src1;
  assign iss_src2_o    = e_src2;
  assign iss_vl_o      = e_vl;

  // State register and scoreboard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      pending <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
    end
  end

  // Entry capture whenever a micro-op is accepted (including discarded ones).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_microop <= '0;
      e_fu      <= 2'b00;
      e_dst     <= 5'd0;
      e_src1    <= 5'd0;
      e_src2    <= 5'd0;
      e_writes  <= 1'b0;
      e_vl      <= '0;
    end else if (accept) begin
      e_microop <= in_microop_i;
      e_fu      <= in_fu_i;
      e_dst     <= in_dst_i;
      e_src1    <= in_src1_i;
      e_src2    <= in_src2_i;
      e_writes  <= in_writes_dst_i;
      e_vl      <= in_vl_i;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: begin
        if (in_valid_i) begin
          state_nx = accept_target(in_reconfigure_i, in_fu_i);
        end else begin
          state_nx = EMPTY;
        end
      end
      HOLD: begin
        if (fire) begin
          if (in_valid_i) begin
            state_nx = accept_target(in_reconfigure_i, in_fu_i);
          end else begin
            state_nx = EMPTY;
          end
        end else begin
          state_nx = HOLD;
        end
      end
      DRAIN: begin
        if (pend_view == '0) begin
          state_nx = CFG;
        end else begin
          state_nx = DRAIN;
        end
      end
      CFG:     state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  // Port strobes decoded from the state and held entry.
  always_comb begin
    ex_valid_o  = 1'b0;
    mem_valid_o = 1'b0;
    cfg_valid_o = 1'b0;
    cfg_vl_o    = '0;
    case (state)
      HOLD: begin
        ex_valid_o  = ~hazard & (e_fu == 2'b10);
        mem_valid_o = ~hazard & (e_fu == 2'b00);
      end
      CFG: begin
        cfg_valid_o = 1'b1;
        cfg_vl_o    = e_vl;
      end
      default: begin
        ex_valid_o  = 1'b0;
        mem_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vissue_ctrl.sv
// Self-checking bench for vissue_ctrl: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_vissue_ctrl;

  localparam int NR = 32;
  localparam int MW = 7;
  localparam int VW = 9;
  localparam int N_RAND_OPS = 300;
  localparam int MAX_CYC = 20000;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [MW-1:0] in_microop;
  logic [1:0] in_fu;
  logic [4:0] in_dst, in_src1, in_src2;
  logic in_writes_dst, in_reconfigure;
  logic [VW-1:0] in_vl;
  logic ex_valid, ex_ready, mem_valid, mem_ready;
  logic [MW-1:0] iss_microop;
  logic [4:0] iss_dst, iss_src1, iss_src2;
  logic [VW-1:0] iss_vl;
  logic cfg_valid;
  logic [VW-1:0] cfg_vl;
  logic wb_ex_valid, wb_mem_valid;
  logic [4:0] wb_ex_dst, wb_mem_dst;
  logic busy;

  always #5 clk = ~clk;

  vissue_ctrl #(.VECTOR_REGISTERS(NR), .MICROOP_WIDTH(MW), .VL_WIDTH(VW)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_microop_i(in_microop),
    .in_fu_i(in_fu), .in_dst_i(in_dst), .in_src1_i(in_src1), .in_src2_i(in_src2),
    .in_writes_dst_i(in_writes_dst), .in_reconfigure_i(in_reconfigure), .in_vl_i(in_vl),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .iss_microop_o(iss_microop), .iss_dst_o(iss_dst), .iss_src1_o(iss_src1),
    .iss_src2_o(iss_src2), .iss_vl_o(iss_vl),
    .cfg_valid_o(cfg_valid), .cfg_vl_o(cfg_vl),
    .wb_ex_valid_i(wb_ex_valid), .wb_ex_dst_i(wb_ex_dst),
    .wb_mem_valid_i(wb_mem_valid), .wb_mem_dst_i(wb_mem_dst),
    .busy_o(busy)
  );

  // kind: 0 execute, 1 memory, 2 configuration, 3 discarded
  typedef struct {
    logic [MW-1:0] uop;
    logic [4:0]    dst;
    logic [4:0]    s1;
    logic [4:0]    s2;
    logic          w;
    logic [VW-1:0] vl;
    int            kind;
  } op_t;

  op_t expq[$];
  op_t cur, got, stash;
  logic [NR-1:0] mpend, clr, setm, eff;
  bit have_op, stall_v, fired;
  int stall_kind, sent, cyc, pulses, at_i;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_microop = '0; in_fu = 2'b00; in_dst = 5'd0;
    in_src1 = 5'd0; in_src2 = 5'd0; in_writes_dst = 1'b0; in_reconfigure = 1'b0;
    in_vl = '0; ex_ready = 1'b0; mem_ready = 1'b0;
    wb_ex_valid = 1'b0; wb_ex_dst = 5'd0; wb_mem_valid = 1'b0; wb_mem_dst = 5'd0;
  endtask

  task automatic drive_op(input logic [MW-1:0] uop, input logic [1:0] fu, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2, input logic w,
                          input logic rc, input logic [VW-1:0] vl);
    in_valid = 1'b1; in_microop = uop; in_fu = fu; in_dst = d; in_src1 = s1;
    in_src2 = s2; in_writes_dst = w; in_reconfigure = rc; in_vl = vl;
  endtask

  function automatic logic [NR-1:0] mask(input logic en, input logic [4:0] idx);
    logic [NR-1:0] m;
    m = '0;
    if (en) m[idx] = 1'b1;
    return m;
  endfunction

  initial begin
    // ---------------- reset ----------------
    idle_inputs();
    rst = 1'b1;
    repeat (2) nxt();
    neg();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_iss_microop", 32'(iss_microop), 32'd0);
    chk("rst_iss_vl", 32'(iss_vl), 32'd0);
    chk("rst_cfg_vl", 32'(cfg_vl), 32'd0);
    nxt();
    rst = 1'b0;
    neg();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // ---------------- vadd dst=3 src=1,2 ----------------
    nxt();
    ex_ready = 1'b1;
    drive_op(7'h11, 2'b10, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 9'd100);
    neg();
    chk("t1_accept_ready", 32'(in_ready), 32'd1);
    chk("t1_no_same_cycle_issue", 32'(ex_valid), 32'd0);
    nxt();
    in_valid = 1'b0;
    neg();
    chk("t1_ex_valid", 32'(ex_valid), 32'd1);
    chk("t1_mem_valid", 32'(mem_valid), 32'd0);
    chk("t1_microop", 32'(iss_microop), 32'h11);
    chk("t1_dst", 32'(iss_dst), 32'd3);
    chk("t1_src1", 32'(iss_src1), 32'd1);
    chk("t1_src2", 32'(iss_src2), 32'd2);
    chk("t1_vl", 32'(iss_vl), 32'd100);
    chk("t1_fire_ready", 32'(in_ready), 32'd1);
    nxt();
    neg();
    chk("t1_ex_drop", 32'(ex_valid), 32'd0);
    chk("t1_busy_pending", 32'(busy), 32'd1);
    nxt();
    wb_ex_valid = 1'b1; wb_ex_dst = 5'd3;
    nxt();
    wb_ex_valid = 1'b0;
    neg();
    chk("t1_busy_cleared", 32'(busy), 32'd0);

    // ---------------- load dst=5, then vadd src1=5 ----------------
    nxt();
    ex_ready = 1'b1; mem_ready = 1'b1;
    drive_op(7'h22, 2'b00, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 9'd8);
    nxt();
    drive_op(7'h23, 2'b10, 5'd6, 5'd5, 5'd4, 1'b1, 1'b0, 9'd8);
    neg();
    chk("t2_mem_valid", 32'(mem_valid), 32'd1);
    chk("t2_ld_dst", 32'(iss_dst), 32'd5);
    chk("t2_fire_ready", 32'(in_ready), 32'd1);
    nxt();
    in_valid = 1'b0;
    neg();
    chk("t2_hazard0", 32'(ex_valid), 32'd0);
    nxt();
    neg();
    chk("t2_hazard1", 32'(ex_valid), 32'd0);
    nxt();
    wb_mem_valid = 1'b1; wb_mem_dst = 5'd5;
    neg();
`ifdef VISSUE_WB_BYPASS_EN
    chk("t2_wb_cycle", 32'(ex_valid), 32'd1);
`else
    chk("t2_wb_cycle", 32'(ex_valid), 32'd0);
`endif
    nxt();
    wb_mem_valid = 1'b0;
    neg();
`ifdef VISSUE_WB_BYPASS_EN
    chk("t2_after_wb", 32'(ex_valid), 32'd0);
`else
    chk("t2_after_wb", 32'(ex_valid), 32'd1);
    chk("t2_src1", 32'(iss_src1), 32'd5);
`endif
    nxt();
    wb_ex_valid = 1'b1; wb_ex_dst = 5'd6;
    nxt();
    wb_ex_valid = 1'b0;
    neg();
    chk("t2_busy_cleared", 32'(busy), 32'd0);

    // ---------------- backpressure ----------------
    nxt();
    ex_ready = 1'b0;
    drive_op(7'h33, 2'b10, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 9'd33);
    nxt();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("t3_stall_valid", 32'(ex_valid), 32'd1);
      chk("t3_stall_microop", 32'(iss_microop), 32'h33);
      chk("t3_stall_dst", 32'(iss_dst), 32'd8);
      chk("t3_stall_vl", 32'(iss_vl), 32'd33);
      chk("t3_stall_ready", 32'(in_ready), 32'd0);
      nxt();
    end
    ex_ready = 1'b1;
    neg();
    chk("t3_release_valid", 32'(ex_valid), 32'd1);
    chk("t3_release_ready", 32'(in_ready), 32'd1);
    nxt();
    neg();
    chk("t3_after_fire", 32'(ex_valid), 32'd0);
    nxt();
    wb_ex_valid = 1'b1; wb_ex_dst = 5'd8;
    nxt();
    wb_ex_valid = 1'b0;

    // ---------------- vset with pending 3 and 7 ----------------
    ex_ready = 1'b1;
    drive_op(7'h41, 2'b10, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 9'd0);
    nxt();
    drive_op(7'h42, 2'b10, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 9'd0);
    nxt();
    drive_op(7'h50, 2'b10, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 9'd64);
    nxt();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("t4_drain_cfg", 32'(cfg_valid), 32'd0);
      chk("t4_drain_ex", 32'(ex_valid), 32'd0);
      chk("t4_drain_busy", 32'(busy), 32'd1);
      nxt();
    end
    wb_ex_valid = 1'b1; wb_ex_dst = 5'd3;
    wb_mem_valid = 1'b1; wb_mem_dst = 5'd7;
    pulses = 0; at_i = -1;
    for (int i = 0; i < 6; i++) begin
      neg();
      if (cfg_valid) begin
        pulses = pulses + 1;
        at_i = i;
        chk("t4_cfg_vl", 32'(cfg_vl), 32'd64);
      end
      nxt();
      wb_ex_valid = 1'b0; wb_mem_valid = 1'b0;
    end
    chk("t4_pulse_count", 32'(pulses), 32'd1);
`ifdef VISSUE_WB_BYPASS_EN
    chk("t4_pulse_cycle", 32'(at_i), 32'd1);
`else
    chk("t4_pulse_cycle", 32'(at_i), 32'd2);
`endif
    neg();
    chk("t4_idle_busy", 32'(busy), 32'd0);

    // ---------------- discard fu=11 ----------------
    nxt();
    drive_op(7'h60, 2'b11, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0, 9'd5);
    neg();
    chk("t5_accept_ready", 32'(in_ready), 32'd1);
    nxt();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("t5_no_ex", 32'(ex_valid), 32'd0);
      chk("t5_no_mem", 32'(mem_valid), 32'd0);
      chk("t5_no_cfg", 32'(cfg_valid), 32'd0);
      chk("t5_ready", 32'(in_ready), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      nxt();
    end

    // ---------------- reset while holding ----------------
    ex_ready = 1'b1;
    drive_op(7'h70, 2'b10, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 9'd1);
    nxt();
    drive_op(7'h71, 2'b10, 5'd9, 5'd2, 5'd0, 1'b1, 1'b0, 9'd1);
    nxt();
    in_valid = 1'b0;
    neg();
    chk("t6_held_blocked", 32'(ex_valid), 32'd0);
    chk("t6_held_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_ex", 32'(ex_valid), 32'd0);
    chk("t6_rst_mem", 32'(mem_valid), 32'd0);
    chk("t6_rst_cfg", 32'(cfg_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_microop", 32'(iss_microop), 32'd0);
    chk("t6_rst_src1", 32'(iss_src1), 32'd0);
    nxt();
    rst = 1'b0;
    neg();
    chk("t6_rel_busy", 32'(busy), 32'd0);
    chk("t6_rel_ready", 32'(in_ready), 32'd1);
    nxt();
    drive_op(7'h72, 2'b10, 5'd11, 5'd2, 5'd2, 1'b0, 1'b0, 9'd1);
    nxt();
    in_valid = 1'b0;
    neg();
    chk("t6_pending_gone", 32'(ex_valid), 32'd1);
    nxt();

    // ---------------- randomized run ----------------
    mpend = '0; have_op = 1'b0; stall_v = 1'b0; sent = 0; cyc = 0; stall_kind = 0;
    while (((sent < N_RAND_OPS) || (expq.size() != 0) || have_op || (mpend != '0)) && (cyc < MAX_CYC)) begin
      cyc = cyc + 1;
      if (!have_op && (sent < N_RAND_OPS) && ($urandom_range(0, 3) != 0)) begin
        cur.uop = 7'($urandom);
        cur.dst = 5'($urandom_range(0, 7));
        cur.s1  = 5'($urandom_range(0, 7));
        cur.s2  = 5'($urandom_range(0, 7));
        cur.w   = 1'($urandom_range(0, 1));
        cur.vl  = 9'($urandom);
        in_fu   = 2'($urandom_range(0, 3));
        in_reconfigure = ($urandom_range(0, 9) == 0);
        if (in_reconfigure) cur.kind = 2;
        else if (in_fu == 2'b10) cur.kind = 0;
        else if (in_fu == 2'b00) cur.kind = 1;
        else cur.kind = 3;
        have_op = 1'b1;
      end
      in_valid = have_op;
      in_microop = cur.uop; in_dst = cur.dst; in_src1 = cur.s1; in_src2 = cur.s2;
      in_writes_dst = cur.w; in_vl = cur.vl;
      ex_ready  = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      wb_ex_valid  = ($urandom_range(0, 2) == 0);
      wb_ex_dst    = 5'($urandom_range(0, 7));
      wb_mem_valid = ($urandom_range(0, 2) == 0);
      wb_mem_dst   = 5'($urandom_range(0, 7));
      clr = mask(wb_ex_valid, wb_ex_dst) | mask(wb_mem_valid, wb_mem_dst);
      eff = mpend & ~clr;
      neg();
      setm = '0;
      if (ex_valid | mem_valid) chk("rnd_one_port", 32'(ex_valid & mem_valid), 32'd0);
      if (stall_v) begin
        chk("rnd_stable_kind", 32'(ex_valid ? 0 : (mem_valid ? 1 : 9)), 32'(stall_kind));
        chk("rnd_stable_uop", 32'(iss_microop), 32'(stash.uop));
        chk("rnd_stable_dst", 32'(iss_dst), 32'(stash.dst));
        chk("rnd_stable_src", 32'({iss_src1, iss_src2}), 32'({stash.s1, stash.s2}));
        chk("rnd_stable_vl", 32'(iss_vl), 32'(stash.vl));
      end
      fired = (ex_valid & ex_ready) | (mem_valid & mem_ready);
      if (fired) begin
        if (expq.size() == 0) begin
          chk("rnd_unexpected_issue", 32'd1, 32'd0);
        end else begin
          got = expq.pop_front();
          chk("rnd_issue_kind", 32'(ex_valid ? 0 : 1), 32'(got.kind));
          chk("rnd_issue_uop", 32'(iss_microop), 32'(got.uop));
          chk("rnd_issue_dst", 32'(iss_dst), 32'(got.dst));
          chk("rnd_issue_src", 32'({iss_src1, iss_src2}), 32'({got.s1, got.s2}));
          chk("rnd_issue_vl", 32'(iss_vl), 32'(got.vl));
          chk("rnd_issue_hazard", 32'(eff[got.s1] | eff[got.s2] | (got.w & eff[got.dst])), 32'd0);
          setm = mask(got.w, got.dst);
        end
      end
      stall_v = (ex_valid | mem_valid) && !fired;
      stall_kind = ex_valid ? 0 : 1;
      stash.uop = iss_microop; stash.dst = iss_dst; stash.s1 = iss_src1;
      stash.s2 = iss_src2; stash.vl = iss_vl;
      if (cfg_valid) begin
        if (expq.size() == 0) begin
          chk("rnd_unexpected_cfg", 32'd1, 32'd0);
        end else begin
          got = expq.pop_front();
          chk("rnd_cfg_kind", 32'd2, 32'(got.kind));
          chk("rnd_cfg_vl", 32'(cfg_vl), 32'(got.vl));
          chk("rnd_cfg_drained", 32'(mpend != '0), 32'd0);
        end
      end
      if (in_valid && in_ready) begin
        if (cur.kind != 3) expq.push_back(cur);
        have_op = 1'b0;
        sent = sent + 1;
      end
      mpend = (mpend & ~clr) | setm;
      nxt();
    end
    idle_inputs();
    chk("rnd_no_timeout", 32'(cyc < MAX_CYC), 32'd1);
    chk("rnd_all_issued", 32'(expq.size()), 32'd0);
    neg();
    chk("rnd_idle_busy", 32'(busy), 32'd0);
    chk("rnd_idle_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
